dpram_req_ctrl: RTL and testbench
=================================

Name: dpram_req_ctrl

Overview:
- Initiator-side front-end for a dual-ported RAM with 1-cycle registered read latency; this is the block that drives the RAM ports.
- Converts two independent valid/ready request channels (port 0, port 1) into RAM port accesses.
- Returns read data on per-port valid/ready response channels, using credit-based flow control over a small response FIFO.
- Resolves same-address write/write collisions between the two ports.

Parameters:
- MD, 16, memory depth; address width AW = `log2(MD).
- DW, 32, data width.
- FD, 3, response FIFO depth per port; minimum 2; 3 gives full read throughput.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- reqVld0/reqVld1  in  1  request valid, port 0/1
- reqRdy0/reqRdy1  out  1  request ready, port 0/1
- reqWe0/reqWe1  in  1  1 = write, 0 = read
- reqAddr0/reqAddr1  in  AW  request address
- reqWData0/reqWData1  in  DW  write data
- rspVld0/rspVld1  out  1  read response valid
- rspRdy0/rspRdy1  in  1  read response ready
- rspData0/rspData1  out  DW  read response data
- wEn0/wEn1  out  1  RAM write enables
- addr0/addr1  out  AW  RAM addresses
- wData0/wData1  out  DW  RAM write data
- rData0/rData1  in  DW  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - All FIFOs empty; pending-read flags cleared.
  - While rst_n=0: rspVld=0, reqRdy=0, wEn=0; addr and wData are don't-care.
  - A reset mid-operation discards in-flight reads and queued responses; no response is produced for them.
- Credit, per port p:
  - credp = FD - occp - pendp, where occp is FIFO occupancy and pendp is 1 if a read was accepted last cycle.
  - baseRdyp = rst_n & (credp > 0).
  - baseRdyp does not depend on reqWe (writes also gated) or on rspRdy, so there is no combinational rspRdy->reqRdy path.
- Collision: stall1 = reqVld0 & baseRdy0 & reqWe0 & reqVld1 & reqWe1 & (reqAddr0 == reqAddr1).
  - reqRdy0 = baseRdy0.
  - reqRdy1 = baseRdy1 & !stall1.
  - Port 0 wins; port 1 retries next cycle and its write then lands last.
  - Read/write to the same address on different ports is not stalled; the RAM's bypass setting defines the read value.
- Acceptance: accp = reqVldp & reqRdyp.
- RAM drive, combinational, same cycle as acceptance:
  - addrp = reqAddrp.
  - wDatap = reqWDatap.
  - wEnp = accp & reqWep.
- Read pipeline:
  - pendp <= accp & !reqWep.
  - The cycle after pendp is set, rDatap is pushed into FIFO p at the clock edge.
  - Latency: read accepted in cycle t -> rspVld=1 with its data in cycle t+2 at the earliest.
- Ordering and response rules:
  - Responses are returned in acceptance order per port.
  - Writes produce no response.
  - rspVldp = occp != 0; rspDatap = FIFO head; pop when rspVldp & rspRdyp.
  - Push and pop in the same cycle leave occp unchanged.
- Overflow: impossible by credit. Pushing into a full FIFO is an assertion failure in simulation.
- Throughput: with FD=3 and rspRdy held at 1, one read per cycle per port is sustained.
- Ports 0 and 1 are fully independent apart from the collision rule.

Decomposition:
- Shared package/header: AW via `log2(MD) from utils.vh; FIFO pointer-width helper.
- Sub-module dpram_rsp_fifo, instantiated twice:
  - Parameters FD, DW.
  - Ports: clk, rst_n, push, pushData, pop, vld, data, occ.
  - Register-based circular buffer; async active-low reset clears pointers and count.

Test Plan:
- Reset then idle: rst_n=0 -> reqRdy0/1=0, rspVld0/1=0, wEn0/1=0. Release -> reqRdy0/1=1 next cycle.
- Write then read: port 0 writes addr 5 = 0xDEADBEEF in cycle 1 -> wEn0=1, addr0=5. Port 0 reads addr 5 in cycle 2 -> rspVld0=1, rspData0=0xDEADBEEF in cycle 4.
- Streaming reads: port 1 reads addrs 0..7 back-to-back with rspRdy1=1 -> reqRdy1 never drops; 8 responses in order, one per cycle, starting 2 cycles after the first accept.
- Backpressure: rspRdy0=0, port 0 issues reads continuously -> exactly FD=3 accepted, then reqRdy0=0. Raise rspRdy0 -> 3 responses in order, then acceptance resumes.
- Collision: both ports write addr 9 in the same cycle (0x11 on port 0, 0x22 on port 1) -> reqRdy1=0 that cycle, port 1 write lands next cycle; a later read of addr 9 returns 0x22.
- Mid-operation reset: two reads queued and one pending, assert rst_n=0 -> rspVld drops immediately; after release no stale response appears and credit is full (3).

Source files
------------

// File: rtl/dpram_req_ctrl_pkg.sv
// Shared widths and helpers for the dual-port RAM request front-end.
package dpram_req_ctrl_pkg;

  localparam int unsigned MD_DEF = 16;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned FD_DEF = 3;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idxW(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold 0..n inclusive.
  function automatic int unsigned cntW(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dpram_rsp_fifo.sv
// Register-based circular response buffer; occupancy exported for credit tracking.
module dpram_rsp_fifo
  import dpram_req_ctrl_pkg::*;
#(
  parameter int unsigned FD = FD_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DW-1:0]         pushData,
  input  logic                  pop,
  output logic                  vld,
  output logic [DW-1:0]         data,
  output logic [cntW(FD)-1:0]   occ
);

  localparam int unsigned PW = idxW(FD);
  localparam int unsigned CW = cntW(FD);

  logic [DW-1:0] mem [FD];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  logic          doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FD - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign doPop = pop & (cnt != '0);
  assign vld   = (cnt != '0);
  assign data  = mem[rdPtr];
  assign occ   = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push)  wrPtr <= nextPtr(wrPtr);
      if (doPop) rdPtr <= nextPtr(rdPtr);
      case ({push, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Credit accounting upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (cnt == CW'(FD))))
        else $error("dpram_rsp_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/dpram_req_ctrl.sv
// Drives both RAM ports from two valid/ready request channels, returning
// read data through credit-protected response FIFOs.
module dpram_req_ctrl
  import dpram_req_ctrl_pkg::*;
#(
  parameter int unsigned MD = MD_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned FD = FD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqVld0,
  input  logic                  reqVld1,
  output logic                  reqRdy0,
  output logic                  reqRdy1,
  input  logic                  reqWe0,
  input  logic                  reqWe1,
  input  logic [idxW(MD)-1:0]   reqAddr0,
  input  logic [idxW(MD)-1:0]   reqAddr1,
  input  logic [DW-1:0]         reqWData0,
  input  logic [DW-1:0]         reqWData1,
  output logic                  rspVld0,
  output logic                  rspVld1,
  input  logic                  rspRdy0,
  input  logic                  rspRdy1,
  output logic [DW-1:0]         rspData0,
  output logic [DW-1:0]         rspData1,
  output logic                  wEn0,
  output logic                  wEn1,
  output logic [idxW(MD)-1:0]   addr0,
  output logic [idxW(MD)-1:0]   addr1,
  output logic [DW-1:0]         wData0,
  output logic [DW-1:0]         wData1,
  input  logic [DW-1:0]         rData0,
  input  logic [DW-1:0]         rData1
);

  localparam int unsigned CW = cntW(FD);

  logic [CW-1:0] occ0;
  logic [CW-1:0] occ1;
  logic          pend0;
  logic          pend1;
  logic          baseRdy0;
  logic          baseRdy1;
  logic          stall1;
  logic          acc0;
  logic          acc1;

  // A slot is reserved for every queued response and the read still in the RAM.
  assign baseRdy0 = rst_n & ((32'(occ0) + 32'(pend0)) < FD);
  assign baseRdy1 = rst_n & ((32'(occ1) + 32'(pend1)) < FD);

  // Same-address double write: port 0 goes first, port 1 lands a cycle later.
  assign stall1 = reqVld0 & baseRdy0 & reqWe0 & reqVld1 & reqWe1 &
                  (reqAddr0 == reqAddr1);

  assign reqRdy0 = baseRdy0;
  assign reqRdy1 = baseRdy1 & ~stall1;
  assign acc0    = reqVld0 & reqRdy0;
  assign acc1    = reqVld1 & reqRdy1;

  assign addr0  = reqAddr0;
  assign addr1  = reqAddr1;
  assign wData0 = reqWData0;
  assign wData1 = reqWData1;
  assign wEn0   = acc0 & reqWe0;
  assign wEn1   = acc1 & reqWe1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      pend0 <= acc0 & ~reqWe0;
      pend1 <= acc1 & ~reqWe1;
    end
  end

  dpram_rsp_fifo #(.FD(FD), .DW(DW)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend0),
    .pushData (rData0),
    .pop      (rspRdy0),
    .vld      (rspVld0),
    .data     (rspData0),
    .occ      (occ0)
  );

  dpram_rsp_fifo #(.FD(FD), .DW(DW)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend1),
    .pushData (rData1),
    .pop      (rspRdy1),
    .vld      (rspVld1),
    .data     (rspData1),
    .occ      (occ1)
  );

endmodule

// File: tb/tb_dpram_req_ctrl.sv
// Directed plus random checks of dpram_req_ctrl against a transaction-level model.
module tb_dpram_req_ctrl;

  localparam int unsigned MD = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 3;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst_n;
  logic          reqVld0, reqVld1, reqRdy0, reqRdy1, reqWe0, reqWe1;
  logic [AW-1:0] reqAddr0, reqAddr1, addr0, addr1;
  logic [DW-1:0] reqWData0, reqWData1, wData0, wData1;
  logic          rspVld0, rspVld1, rspRdy0, rspRdy1, wEn0, wEn1;
  logic [DW-1:0] rspData0, rspData1, rData0, rData1;

  int checks = 0;
  int errors = 0;

  // RAM environment: read-first, one-cycle registered read.
  logic [DW-1:0] ram [MD];

  // Reference model state.
  logic [DW-1:0] refMem [MD];
  logic [DW-1:0] rq [2][$];
  logic          pendV [2];
  logic [DW-1:0] pendD [2];

  dpram_req_ctrl #(.MD(MD), .DW(DW), .FD(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqVld0(reqVld0), .reqVld1(reqVld1), .reqRdy0(reqRdy0), .reqRdy1(reqRdy1),
    .reqWe0(reqWe0), .reqWe1(reqWe1), .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
    .reqWData0(reqWData0), .reqWData1(reqWData1),
    .rspVld0(rspVld0), .rspVld1(rspVld1), .rspRdy0(rspRdy0), .rspRdy1(rspRdy1),
    .rspData0(rspData0), .rspData1(rspData1),
    .wEn0(wEn0), .wEn1(wEn1), .addr0(addr0), .addr1(addr1),
    .wData0(wData0), .wData1(wData1), .rData0(rData0), .rData1(rData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wEn0) ram[addr0] <= wData0;
    if (wEn1) ram[addr1] <= wData1;
    rData0 <= ram[addr0];
    rData1 <= ram[addr1];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Checks one cycle (inputs already applied at the falling edge), then
  // advances the model across the next rising edge.
  task automatic step(input string tag);
    logic          v [2], we [2], rr [2], eRdy [2], acc [2], oRdy [2], oVld [2], oWe [2];
    logic [AW-1:0] a [2], oAddr [2];
    logic [DW-1:0] wd [2], oData [2], oWd [2];
    logic          stall;
    int            cred;
    #1;
    v[0] = reqVld0;  v[1] = reqVld1;  we[0] = reqWe0;  we[1] = reqWe1;
    rr[0] = rspRdy0; rr[1] = rspRdy1; a[0] = reqAddr0; a[1] = reqAddr1;
    wd[0] = reqWData0; wd[1] = reqWData1;
    oRdy[0] = reqRdy0; oRdy[1] = reqRdy1; oVld[0] = rspVld0; oVld[1] = rspVld1;
    oWe[0] = wEn0; oWe[1] = wEn1; oAddr[0] = addr0; oAddr[1] = addr1;
    oWd[0] = wData0; oWd[1] = wData1; oData[0] = rspData0; oData[1] = rspData1;
    for (int p = 0; p < 2; p++) begin
      cred = int'(FD) - rq[p].size() - (pendV[p] ? 1 : 0);
      eRdy[p] = rst_n && (cred > 0);
    end
    stall = v[0] && eRdy[0] && we[0] && v[1] && we[1] && (a[0] == a[1]);
    if (stall) eRdy[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      acc[p] = v[p] && eRdy[p];
      chk($sformatf("%s_reqRdy%0d", tag, p), DW'(oRdy[p]), DW'(eRdy[p]));
      chk($sformatf("%s_rspVld%0d", tag, p), DW'(oVld[p]), DW'(rst_n && rq[p].size() != 0));
      chk($sformatf("%s_wEn%0d", tag, p), DW'(oWe[p]), DW'(acc[p] && we[p]));
      if (rst_n && rq[p].size() != 0)
        chk($sformatf("%s_rspData%0d", tag, p), oData[p], rq[p][0]);
      if (acc[p] && we[p]) begin
        chk($sformatf("%s_addr%0d", tag, p), DW'(oAddr[p]), DW'(a[p]));
        chk($sformatf("%s_wData%0d", tag, p), oWd[p], wd[p]);
      end
    end
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rq[p].delete();
        pendV[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rq[p].size() != 0 && rr[p]) void'(rq[p].pop_front());
        if (pendV[p]) rq[p].push_back(pendD[p]);
        pendV[p] = acc[p] && !we[p];
        pendD[p] = refMem[a[p]];
      end
      for (int p = 0; p < 2; p++)
        if (acc[p] && we[p]) refMem[a[p]] = wd[p];
    end
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < int'(MD); i++) begin
      ram[i] = '0;
      refMem[i] = '0;
    end
    pendV[0] = 1'b0; pendV[1] = 1'b0;
    pendD[0] = '0;   pendD[1] = '0;
    rst_n = 1'b0;
    reqVld0 = 0; reqVld1 = 0; reqWe0 = 0; reqWe1 = 0;
    reqAddr0 = '0; reqAddr1 = '0; reqWData0 = '0; reqWData1 = '0;
    rspRdy0 = 0; rspRdy1 = 0;
    @(negedge clk);

    // Reset and idle
    reqVld0 = 1; reqVld1 = 1;
    step("rst");
    #1 chk("rst_reqRdy0_c", DW'(reqRdy0), '0);
    step("rst2");
    reqVld0 = 0; reqVld1 = 0;
    rst_n = 1'b1;
    #1 chk("rel_reqRdy1_c", DW'(reqRdy1), DW'(1));
    step("idle");

    // Write then read back with two-cycle latency
    reqVld0 = 1; reqWe0 = 1; reqAddr0 = 4'd5; reqWData0 = 32'hDEADBEEF;
    step("wr");
    reqWe0 = 0;
    step("rd");
    reqVld0 = 0; rspRdy0 = 1;
    #1 chk("lat1_vld_c", DW'(rspVld0), '0);
    step("lat1");
    #1 chk("lat2_vld_c", DW'(rspVld0), DW'(1));
    chk("lat2_data_c", rspData0, 32'hDEADBEEF);
    step("lat2");
    step("lat3");

    // Preload 0..7 through port 0, then stream reads on port 1
    reqVld0 = 1; reqWe0 = 1;
    for (int i = 0; i < 8; i++) begin
      reqAddr0 = AW'(i); reqWData0 = $urandom;
      step("pre");
    end
    reqVld0 = 0; reqWe0 = 0;
    reqVld1 = 1; rspRdy1 = 1;
    for (int i = 0; i < 8; i++) begin
      reqAddr1 = AW'(i);
      step("strm");
    end
    reqVld1 = 0;
    for (int i = 0; i < 4; i++) step("strm_drain");

    // Backpressure: exactly FD reads accepted, then resume
    rspRdy0 = 0; reqVld0 = 1; reqWe0 = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      reqAddr0 = AW'(i);
      #1 if (reqRdy0) cnt++;
      step("bp");
    end
    chk("bp_accepted_c", DW'(cnt), DW'(FD));
    rspRdy0 = 1;
    for (int i = 0; i < 6; i++) begin
      reqAddr0 = AW'(i + 6);
      step("bp_rel");
    end
    reqVld0 = 0;
    for (int i = 0; i < 4; i++) step("bp_drain");

    // Same-address write collision
    reqVld0 = 1; reqVld1 = 1; reqWe0 = 1; reqWe1 = 1;
    reqAddr0 = 4'd9; reqAddr1 = 4'd9; reqWData0 = 32'h11; reqWData1 = 32'h22;
    #1 chk("coll_reqRdy1_c", DW'(reqRdy1), '0);
    step("coll");
    reqVld0 = 0;
    #1 chk("coll_retry_wEn1_c", DW'(wEn1), DW'(1));
    step("coll_retry");
    reqVld1 = 0; reqWe1 = 0;
    reqVld0 = 1; reqWe0 = 0; rspRdy0 = 1;
    step("coll_rd");
    reqVld0 = 0;
    step("coll_rd1");
    #1 chk("coll_val_c", rspData0, 32'h22);
    step("coll_rd2");

    // Reset with two responses queued and one read in flight
    rspRdy0 = 0; reqVld0 = 1;
    for (int i = 0; i < 3; i++) begin
      reqAddr0 = AW'(i + 1);
      step("mr_fill");
    end
    reqVld0 = 0;
    rst_n = 1'b0;
    #1 chk("mr_vld_drop_c", DW'(rspVld0), '0);
    step("mr");
    rst_n = 1'b1; rspRdy0 = 1;
    for (int i = 0; i < 3; i++) step("mr_post");
    rspRdy0 = 0; reqVld0 = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (reqRdy0) cnt++;
      step("mr_cred");
    end
    chk("mr_credit_c", DW'(cnt), DW'(FD));
    reqVld0 = 0; rspRdy0 = 1;
    for (int i = 0; i < 4; i++) step("mr_drain");

    // Randomized traffic including collisions and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      reqVld0   = $urandom_range(0, 3) != 0;
      reqVld1   = $urandom_range(0, 3) != 0;
      reqWe0    = $urandom_range(0, 1) != 0;
      reqWe1    = $urandom_range(0, 1) != 0;
      reqAddr0  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      reqAddr1  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      reqWData0 = $urandom;
      reqWData1 = $urandom;
      rspRdy0   = $urandom_range(0, 2) != 0;
      rspRdy1   = $urandom_range(0, 2) != 0;
      step("rnd");
    end
    rst_n = 1'b1; reqVld0 = 0; reqVld1 = 0; rspRdy0 = 1; rspRdy1 = 1;
    for (int i = 0; i < 6; i++) step("end_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
